// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcode, ALU-op and state encodings shared by the multicycle controller
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE_LOGIC = 4'b0000;
    localparam logic [3:0] OP_RTYPE_ARITH = 4'b0001;
    localparam logic [3:0] OP_ADDI        = 4'b1001;
    localparam logic [3:0] OP_SUBI        = 4'b1010;
    localparam logic [3:0] OP_SLTI        = 4'b1011;
    localparam logic [3:0] OP_LW          = 4'b1100;
    localparam logic [3:0] OP_SW          = 4'b1101;
    localparam logic [3:0] OP_BEQ         = 4'b1110;
    localparam logic [3:0] OP_HALT        = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // Encoding 12 is unused; TRAP sits at 13 so debug tools can key on it.
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_WB_R     = 4'd3;
    localparam logic [3:0] ST_EXEC_I   = 4'd4;
    localparam logic [3:0] ST_WB_I     = 4'd5;
    localparam logic [3:0] ST_MEM_ADDR = 4'd6;
    localparam logic [3:0] ST_MEM_RD   = 4'd7;
    localparam logic [3:0] ST_WB_MEM   = 4'd8;
    localparam logic [3:0] ST_MEM_WR   = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_HALT     = 4'd11;
    localparam logic [3:0] ST_TRAP     = 4'd13;

    typedef enum logic [3:0] {
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_EXEC_R   = ST_EXEC_R,
        S_WB_R     = ST_WB_R,
        S_EXEC_I   = ST_EXEC_I,
        S_WB_I     = ST_WB_I,
        S_MEM_ADDR = ST_MEM_ADDR,
        S_MEM_RD   = ST_MEM_RD,
        S_WB_MEM   = ST_WB_MEM,
        S_MEM_WR   = ST_MEM_WR,
        S_BRANCH   = ST_BRANCH,
        S_HALT     = ST_HALT,
        S_TRAP     = ST_TRAP
    } state_e;

    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - counts cycles spent in a memory wait state and flags bus timeout
module ctrl_wait_timer #(
    parameter int BUS_TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the last allowed wait cycle; the caller lets a same-cycle ready win.
    assign expired_o = (BUS_TIMEOUT != 0) && enable_i && (count_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM; CTRL_RETIRE_CNT_EN adds RetireCount
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 64
`ifdef CTRL_RETIRE_CNT_EN
    , parameter int COUNT_W = 16
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Opcode,
    input  logic       ImemReady,
    input  logic       DmemReady,
    output logic       ImemReq,
    output logic       IrWrite,
    output logic       PcWrite,
    output logic       PcWriteCond,
    output logic       RegDst,
    output logic       AluSrc,
    output logic [1:0] AluOp,
    output logic       MemToReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       Halted,
    output logic       Trap,
    output logic [3:0] State
`ifdef CTRL_RETIRE_CNT_EN
    , output logic [COUNT_W-1:0] RetireCount
`endif
);

    state_e state_q, state_d;
    logic   expired;
    logic   wait_clear;
    logic   wait_enable;

    assign wait_enable = is_wait_state(state_q);
    assign wait_clear  = is_wait_state(state_d) && (state_d != state_q);

    ctrl_wait_timer #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_wait_timer (
        .clk_i     (Clock),
        .rst_i     (Reset),
        .clear_i   (wait_clear),
        .enable_i  (wait_enable),
        .expired_o (expired)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ImemReq     = 1'b0;
        IrWrite     = 1'b0;
        PcWrite     = 1'b0;
        PcWriteCond = 1'b0;
        RegDst      = 1'b0;
        AluSrc      = 1'b0;
        AluOp       = ALUOP_ADD;
        MemToReg    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        Halted      = 1'b0;
        Trap        = 1'b0;
        case (state_q)
            S_FETCH: begin
                ImemReq = 1'b1;
                if (ImemReady) begin
                    IrWrite = 1'b1;
                    PcWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE_LOGIC, OP_RTYPE_ARITH: state_d = S_EXEC_R;
                    OP_ADDI, OP_SUBI, OP_SLTI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW:                   state_d = S_MEM_ADDR;
                    OP_BEQ:                         state_d = S_BRANCH;
                    OP_HALT:                        state_d = S_HALT;
                    default:                        state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                RegDst  = 1'b1;
                AluOp   = ALUOP_RTYPE;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                RegDst   = 1'b1;
                AluOp    = ALUOP_RTYPE;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXEC_I: begin
                AluSrc  = 1'b1;
                AluOp   = ALUOP_ITYPE;
                state_d = S_WB_I;
            end
            S_WB_I: begin
                AluSrc   = 1'b1;
                AluOp    = ALUOP_ITYPE;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_ADDR: begin
                AluSrc  = 1'b1;
                state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                AluSrc  = 1'b1;
                MemRead = 1'b1;
                if (DmemReady) begin
                    state_d = S_WB_MEM;
                end else if (expired) begin
                    state_d = S_TRAP;
                end
            end
            S_WB_MEM: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                AluSrc   = 1'b1;
                MemWrite = 1'b1;
                if (DmemReady) begin
                    state_d = S_FETCH;
                end else if (expired) begin
                    state_d = S_TRAP;
                end
            end
            S_BRANCH: begin
                AluOp       = ALUOP_SUB;
                PcWriteCond = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: Halted = 1'b1;
            S_TRAP: Trap = 1'b1;
            default: state_d = S_TRAP;
        endcase
    end

    assign State = state_q;

`ifdef CTRL_RETIRE_CNT_EN
    logic [COUNT_W-1:0] retire_q, retire_d;
    logic               retire;

    assign retire = (state_q == S_WB_R) || (state_q == S_WB_I) || (state_q == S_WB_MEM)
                 || (state_q == S_BRANCH) || ((state_q == S_MEM_WR) && DmemReady);

    always_comb begin
        retire_d = retire_q;
        if (retire) begin
            retire_d = retire_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign RetireCount = retire_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with a 4-cycle bus timeout
module tb_multicycle_ctrl;

    localparam logic [3:0] FETCH = 4'd0,  DECODE = 4'd1,  EXEC_R = 4'd2,  WB_R = 4'd3;
    localparam logic [3:0] EXEC_I = 4'd4, WB_I = 4'd5,    MEM_ADDR = 4'd6, MEM_RD = 4'd7;
    localparam logic [3:0] WB_MEM = 4'd8, MEM_WR = 4'd9,  BRANCH = 4'd10, HALT = 4'd11;
    localparam logic [3:0] TRAP = 4'd13;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] Opcode;
    logic       ImemReady, DmemReady;
    logic       ImemReq, IrWrite, PcWrite, PcWriteCond, RegDst, AluSrc;
    logic [1:0] AluOp;
    logic       MemToReg, MemRead, MemWrite, RegWrite, Halted, Trap;
    logic [3:0] State;
`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0] RetireCount;
    logic [15:0] exp_ret;
`endif

    int checks = 0;
    int failures = 0;
    logic [17:0] exp_q[$];

    multicycle_ctrl #(.BUS_TIMEOUT(4)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Opcode      (Opcode),
        .ImemReady   (ImemReady),
        .DmemReady   (DmemReady),
        .ImemReq     (ImemReq),
        .IrWrite     (IrWrite),
        .PcWrite     (PcWrite),
        .PcWriteCond (PcWriteCond),
        .RegDst      (RegDst),
        .AluSrc      (AluSrc),
        .AluOp       (AluOp),
        .MemToReg    (MemToReg),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .Halted      (Halted),
        .Trap        (Trap),
        .State       (State)
`ifdef CTRL_RETIRE_CNT_EN
        , .RetireCount (RetireCount)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {ImemReq, IrWrite, PcWrite, PcWriteCond, RegDst, AluSrc, AluOp, MemToReg, MemRead, MemWrite, RegWrite, Halted, Trap}
    function automatic logic [13:0] ctl(input logic [3:0] st, input logic imem);
        logic ireq, irw, pcw, pcc, rdst, asrc, m2r, mrd, mwr, rw, hlt, trp;
        logic [1:0] aop;
        {ireq, irw, pcw, pcc, rdst, asrc, m2r, mrd, mwr, rw, hlt, trp} = '0;
        aop = 2'b00;
        case (st)
            FETCH:    begin ireq = 1'b1; irw = imem; pcw = imem; end
            EXEC_R:   begin rdst = 1'b1; aop = 2'b01; end
            WB_R:     begin rdst = 1'b1; aop = 2'b01; rw = 1'b1; end
            EXEC_I:   begin asrc = 1'b1; aop = 2'b11; end
            WB_I:     begin asrc = 1'b1; aop = 2'b11; rw = 1'b1; end
            MEM_ADDR: asrc = 1'b1;
            MEM_RD:   begin asrc = 1'b1; mrd = 1'b1; end
            WB_MEM:   begin m2r = 1'b1; rw = 1'b1; end
            MEM_WR:   begin asrc = 1'b1; mwr = 1'b1; end
            BRANCH:   begin pcc = 1'b1; aop = 2'b10; end
            HALT:     hlt = 1'b1;
            TRAP:     trp = 1'b1;
            default:  ;
        endcase
        return {ireq, irw, pcw, pcc, rdst, asrc, aop, m2r, mrd, mwr, rw, hlt, trp};
    endfunction

    task automatic step(input string tag, input logic rst, input logic imem, input logic dmem,
                        input logic [3:0] op, input logic [3:0] exp_st);
        logic [17:0] got;
        Reset = rst;
        ImemReady = imem;
        DmemReady = dmem;
        Opcode = op;
        exp_q.push_back({exp_st, ctl(exp_st, imem)});
        @(negedge Clock);
        got = {State, ImemReq, IrWrite, PcWrite, PcWriteCond, RegDst, AluSrc, AluOp,
               MemToReg, MemRead, MemWrite, RegWrite, Halted, Trap};
        check_eq(tag, 32'(got), 32'(exp_q.pop_front()));
`ifdef CTRL_RETIRE_CNT_EN
        check_eq({tag, "_ret"}, 32'(RetireCount), 32'(exp_ret));
        if (rst)
            exp_ret = '0;
        else if (exp_st == WB_R || exp_st == WB_I || exp_st == WB_MEM || exp_st == BRANCH
                 || (exp_st == MEM_WR && dmem))
            exp_ret = exp_ret + 16'd1;
`endif
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        ImemReady = 1'b0;
        DmemReady = 1'b0;
        Opcode = 4'h0;
`ifdef CTRL_RETIRE_CNT_EN
        exp_ret = '0;
`endif
        @(posedge Clock);
        #1;

        step("rst_state", 0, 0, 0, 4'h0, FETCH);

        step("add_f",  0, 1, 0, 4'h1, FETCH);
        step("add_d",  0, 1, 1, 4'h1, DECODE);
        step("add_x",  0, 1, 0, 4'hF, EXEC_R);
        step("add_wb", 0, 1, 0, 4'hF, WB_R);

        step("lw_f",   0, 1, 0, 4'hC, FETCH);
        step("lw_d",   0, 1, 0, 4'hC, DECODE);
        step("lw_a",   0, 1, 0, 4'hC, MEM_ADDR);
        for (int i = 0; i < 3; i++) step("lw_rd_wait", 0, 1, 0, 4'hC, MEM_RD);
        step("lw_rd",  0, 1, 1, 4'hC, MEM_RD);
        step("lw_wb",  0, 1, 0, 4'hC, WB_MEM);

        step("sw_f",   0, 1, 0, 4'hD, FETCH);
        step("sw_d",   0, 1, 0, 4'hD, DECODE);
        step("sw_a",   0, 1, 0, 4'hD, MEM_ADDR);
        step("sw_wr",  0, 1, 1, 4'hD, MEM_WR);
        step("beq_f",  0, 1, 0, 4'hE, FETCH);
        step("beq_d",  0, 1, 0, 4'hE, DECODE);
        step("beq_br", 0, 1, 0, 4'hE, BRANCH);

        for (int i = 0; i < 4; i++) step("to_fetch", 0, 0, 0, 4'h1, FETCH);
        step("to_trap",   0, 1, 0, 4'h1, TRAP);
        step("to_stay",   1, 1, 0, 4'h1, TRAP);

        for (int i = 0; i < 3; i++) step("late_fetch", 0, 0, 0, 4'h9, FETCH);
        step("late_rdy",  0, 1, 0, 4'h9, FETCH);
        step("late_d",    0, 1, 0, 4'h9, DECODE);
        step("addi_x",    0, 1, 0, 4'h0, EXEC_I);
        step("addi_wb",   0, 1, 0, 4'h0, WB_I);

        step("rdto_f",    0, 1, 0, 4'hC, FETCH);
        step("rdto_d",    0, 1, 0, 4'hC, DECODE);
        step("rdto_a",    0, 1, 0, 4'hC, MEM_ADDR);
        for (int i = 0; i < 4; i++) step("rdto_wait", 0, 1, 0, 4'hC, MEM_RD);
        step("rdto_trap", 1, 1, 1, 4'hC, TRAP);

        step("ill_f",     0, 1, 0, 4'h5, FETCH);
        step("ill_d",     0, 1, 0, 4'h5, DECODE);
        step("ill_trap",  1, 1, 0, 4'h5, TRAP);

        step("halt_f",    0, 1, 0, 4'hF, FETCH);
        step("halt_d",    0, 1, 0, 4'hF, DECODE);
        step("halt_1",    0, 1, 1, 4'h1, HALT);
        step("halt_2",    0, 1, 0, 4'h1, HALT);
        step("halt_rst",  1, 1, 0, 4'h1, HALT);

        step("mid_f",     0, 1, 0, 4'hC, FETCH);
        step("mid_d",     0, 1, 0, 4'hC, DECODE);
        step("mid_a",     0, 1, 0, 4'hC, MEM_ADDR);
        step("mid_rd",    0, 1, 0, 4'hC, MEM_RD);
        step("mid_rst",   1, 1, 1, 4'hC, MEM_RD);
        step("mid_after", 0, 0, 0, 4'hC, FETCH);
        step("mid_next",  0, 0, 0, 4'hC, FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit CPU datapath.
- Drives PC, IR, register file, ALU and data-memory control from a Moore FSM, one instruction at a time.
- Handles variable-latency instruction and data memories through req/ready handshakes, with an optional bus timeout.
- Replaces the single-cycle opcode decode as the top-level control source.

Parameters:
- BUS_TIMEOUT, 64, max wait cycles for imem/dmem ready before trapping; 0 disables the timeout.
- COUNT_W, 16, width of RetireCount (used only with the optional feature).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Opcode  in  4  IR[15:12]; valid from DECODE onward.
- ImemReady  in  1  instruction word available this cycle.
- DmemReady  in  1  data read/write completes this cycle.
- ImemReq  out  1  instruction fetch request.
- IrWrite  out  1  load IR.
- PcWrite  out  1  PC <= PC+2.
- PcWriteCond  out  1  PC <= branch target if ALU Zero; the datapath does the gating.
- RegDst  out  1  1 selects rd, 0 selects rt.
- AluSrc  out  1  1 selects the immediate.
- AluOp  out  2  00 = add (address), 01 = R-type funct, 10 = sub (branch), 11 = I-type.
- MemToReg  out  1  write-back data comes from memory.
- MemRead  out  1  dmem read request.
- MemWrite  out  1  dmem write request.
- RegWrite  out  1  register file write enable.
- Halted  out  1  FSM is in HALT.
- Trap  out  1  FSM is in TRAP.
- State  out  4  current state encoding, for debug.
- RetireCount  out  COUNT_W  present only with CTRL_RETIRE_CNT_EN.

Behaviour:
- Opcodes:
  - 0000 AND/OR/XOR, 0001 ADD/SUB: R-type.
  - 1001 ADDI, 1010 SUBI, 1011 SLTI: I-type.
  - 1100 LW, 1101 SW, 1110 BEQ, 1111 HALT.
  - All others are illegal.
- Reset: on a Clock edge with Reset=1, State <= FETCH, wait counter <= 0, RetireCount <= 0. Reset overrides any in-flight request; the request is dropped and not retried.
- Outputs are decoded from State. Default for every output is 0; only the listed outputs are nonzero in each state.
- Post-reset output values: ImemReq=1, everything else 0.
- FETCH:
  - ImemReq=1.
  - When ImemReady=1 (same cycle, Mealy-qualified): IrWrite=1, PcWrite=1, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, all outputs 0. Next state by Opcode:
  - R-type -> EXEC_R.
  - I-type -> EXEC_I.
  - LW/SW -> MEM_ADDR.
  - BEQ -> BRANCH.
  - 1111 -> HALT.
  - else -> TRAP.
- EXEC_R: RegDst=1, AluOp=01. Next WB_R.
- WB_R: RegDst=1, AluOp=01, RegWrite=1. Next FETCH.
- EXEC_I: AluSrc=1, AluOp=11. Next WB_I.
- WB_I: AluSrc=1, AluOp=11, RegWrite=1. Next FETCH.
- MEM_ADDR: AluSrc=1, AluOp=00. Next MEM_RD if Opcode=1100, else MEM_WR.
- MEM_RD:
  - AluSrc=1, AluOp=00, MemRead=1, held until DmemReady.
  - On DmemReady -> WB_MEM.
- WB_MEM: MemToReg=1, RegWrite=1, RegDst=0. Next FETCH.
- MEM_WR:
  - AluSrc=1, AluOp=00, MemWrite=1, held until DmemReady.
  - On DmemReady -> FETCH.
- BRANCH: AluOp=10, PcWriteCond=1. Next FETCH.
- HALT: Halted=1. Terminal until Reset.
- TRAP: Trap=1. Terminal until Reset.
- Zero-wait latencies: R/I 4 cycles, LW 5, SW 4, BEQ 3.
- Ready outside a waiting state (FETCH, MEM_RD, MEM_WR) is ignored.
- Wait counter:
  - Clears on entry to each waiting state and counts cycles spent there.
  - If BUS_TIMEOUT!=0 and the counter reaches BUS_TIMEOUT-1 with no ready, next state is TRAP.
  - Ready in that same cycle wins: normal transition.
- Opcode is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.

Optional Feature:
- Macro CTRL_RETIRE_CNT_EN.
- Defined:
  - RetireCount increments by 1 on the final cycle of each retired instruction: WB_R, WB_I, WB_MEM, BRANCH, and MEM_WR with DmemReady.
  - Wraps modulo 2^COUNT_W.
  - HALT and TRAP do not count.
- Undefined: the port and counter are absent; FSM behaviour is identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants;
  - AluOp encodings (ALUOP_ADD/RTYPE/SUB/ITYPE);
  - the state encoding localparams (FETCH=0 … TRAP=13).
- Sub-module ctrl_wait_timer (BUS_TIMEOUT): inputs clear/enable, output expired. Instantiated once.

Test Plan:
- Reset, then ImemReady=1 always, Opcode=0001 -> States FETCH, DECODE, EXEC_R, WB_R, FETCH; RegWrite=1 only in cycle 4; RetireCount=1.
- LW (1100) with DmemReady delayed 3 cycles -> MemRead held 4 cycles; WB_MEM has MemToReg=1, RegWrite=1; total 8 cycles.
- SW (1101) then BEQ (1110), zero-wait -> MemWrite=1 for 1 cycle; then PcWriteCond=1, AluOp=10 in BRANCH; RetireCount=2.
- BUS_TIMEOUT=4, ImemReady=0 -> Trap=1 after 4 FETCH cycles. Repeat with ready arriving on cycle 4 -> DECODE, no trap.
- Opcode=0101 -> TRAP. Opcode=1111 -> Halted=1 and stays; Reset asserted mid-MEM_RD -> FETCH next edge, MemRead=0, ImemReq=1.
